// File: rtl/fetch_sequencer_if.sv
// +----------------------------------------------------------------------+
// | fetch_sequencer_if : control, ROM and display signals of the fetch   |
// |                      sequencer                                        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface fetch_sequencer_if;
   logic        step;
   logic        run;
   logic [1:0]  select;
   logic [31:0] rom_data;
   logic [5:0]  rom_addr;
   logic        rom_en;
   logic [31:0] pc;
   logic [31:0] ir;
   logic        ir_valid;
   logic        busy;
   logic [7:0]  led;

   modport master (
      input  step, run, select, rom_data,
      output rom_addr, rom_en, pc, ir, ir_valid, busy, led
   );

   modport slave (
      output step, run, select, rom_data,
      input  rom_addr, rom_en, pc, ir, ir_valid, busy, led
   );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// +----------------------------------------------------------------------+
// | fetch_sequencer : PC / IR owner that sequences synchronous ROM reads |
// |                   on Step pulses or a free-run timer                 |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_sequencer #(
   parameter int          ROM_LAT  = 1,
   parameter int          RUN_DIV  = 25,
   parameter logic [31:0] PC_RESET = 32'h0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   fetch_sequencer_if.master  bus
);

   localparam int         RUN_W    = $clog2(RUN_DIV);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);
   localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       lat_q, lat_d;
   logic             pending_q, pending_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic             ir_valid_q, ir_valid_d;
   logic             rom_en_q, rom_en_d;
   logic             busy_q, busy_d;
   logic [7:0]       led_q, led_d;
   logic             run_expire;

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      pending_d  = pending_q;
      run_cnt_d  = run_cnt_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = 1'b0;
      led_d      = ir_q[{bus.select, 3'b000} +: 8];
      run_expire = bus.run && (state_q == S_IDLE) && (run_cnt_q == RUN_LAST);

      // The timer only advances while idle, so a fetch stretches the interval.
      if (!bus.run) begin
         run_cnt_d = '0;
      end else if (state_q == S_IDLE) begin
         run_cnt_d = run_expire ? '0 : run_cnt_q + RUN_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (bus.step || pending_q || run_expire) begin
               state_d   = S_ISSUE;
               pending_d = 1'b0;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            lat_d   = LAT_LAST;
            if (bus.step) pending_d = 1'b1;
         end
         S_WAIT: begin
            if (bus.step) pending_d = 1'b1;
            if (lat_q == 2'd0) begin
               state_d    = S_IDLE;
               ir_d       = bus.rom_data;
               pc_d       = pc_q + 32'd4;
               ir_valid_d = 1'b1;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      rom_en_d = (state_d == S_ISSUE);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         lat_q      <= 2'd0;
         pending_q  <= 1'b0;
         run_cnt_q  <= '0;
         pc_q       <= PC_RESET;
         ir_q       <= 32'h0;
         ir_valid_q <= 1'b0;
         rom_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         led_q      <= 8'h0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         pending_q  <= pending_d;
         run_cnt_q  <= run_cnt_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         rom_en_q   <= rom_en_d;
         busy_q     <= busy_d;
         led_q      <= led_d;
      end
   end

   assign bus.rom_addr = pc_q[7:2];
   assign bus.rom_en   = rom_en_q;
   assign bus.pc       = pc_q;
   assign bus.ir       = ir_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.busy     = busy_q;
   assign bus.led      = led_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_fetch_sequencer : directed and random stimulus against a          |
// |                      fetch-level reference model                     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_sequencer;
   localparam int ROM_LAT = 1;
   localparam int RUN_DIV = 25;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .ROM_LAT  (ROM_LAT),
      .RUN_DIV  (RUN_DIV),
      .PC_RESET (32'h0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   logic [31:0] mem [64];

   // One-cycle ROM: valid only on the cycle after an enabled sample, junk otherwise.
   always @(posedge clk) begin
      bus.rom_data <= bus.rom_en ? mem[bus.rom_addr] : $urandom();
   end

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: fetch started at edge m_start completes ROM_LAT+1 edges later.
   int          n;
   int          m_start;
   logic        m_pending;
   int          m_cnt;
   logic [31:0] m_pc, m_ir;
   logic        m_valid, m_rom_en;
   logic [7:0]  m_led;

   task automatic model_reset();
      m_start   = -1;
      m_pending = 1'b0;
      m_cnt     = 0;
      m_pc      = 32'h0;
      m_ir      = 32'h0;
      m_valid   = 1'b0;
      m_rom_en  = 1'b0;
      m_led     = 8'h0;
   endtask

   task automatic model_edge(input logic s, input logic r, input logic [1:0] sel);
      logic [7:0] led_new;
      logic       expire;
      n++;
      led_new  = m_ir[8*sel +: 8];
      m_valid  = 1'b0;
      m_rom_en = 1'b0;
      if (m_start >= 0) begin
         if (s) m_pending = 1'b1;
         if (n == m_start + ROM_LAT + 1) begin
            m_ir    = mem[m_pc[7:2]];
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_start = -1;
         end
         if (!r) m_cnt = 0;
      end else begin
         expire = r && (m_cnt == RUN_DIV - 1);
         m_cnt  = (!r || expire) ? 0 : m_cnt + 1;
         if (s || m_pending || expire) begin
            m_start   = n;
            m_pending = 1'b0;
            m_rom_en  = 1'b1;
         end
      end
      m_led = led_new;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("rom_addr", {26'b0, bus.rom_addr}, {26'b0, m_pc[7:2]});
      chk("rom_en",   {31'b0, bus.rom_en},   {31'b0, m_rom_en});
      chk("pc",       bus.pc,                m_pc);
      chk("ir",       bus.ir,                m_ir);
      chk("ir_valid", {31'b0, bus.ir_valid}, {31'b0, m_valid});
      chk("busy",     {31'b0, bus.busy},     {31'b0, m_start >= 0});
      chk("led",      {24'b0, bus.led},      {24'b0, m_led});
   endtask

   task automatic tick(input logic s, input logic r, input logic [1:0] sel);
      bus.step   = s;
      bus.run    = r;
      bus.select = sel;
      @(posedge clk);
      model_edge(s, r, sel);
      #1;
      check_all();
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] pc_before;
      int          got, last, k;

      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      mem[0] = 32'h2001_0005;
      n = 0;
      model_reset();
      rst_n      = 1'b0;
      bus.step   = 1'b0;
      bus.run    = 1'b0;
      bus.select = 2'd0;
      #1;
      check_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      #3;
      rst_n = 1'b1;

      // Single step, ROM word 0, LED on top byte.
      tick(1'b1, 1'b0, 2'd3);
      chk("t1_rom_en", {31'b0, bus.rom_en}, 32'd1);
      chk("t1_addr", {26'b0, bus.rom_addr}, 32'd0);
      tick(1'b0, 1'b0, 2'd3);
      tick(1'b0, 1'b0, 2'd3);
      chk("t1_ir", bus.ir, 32'h2001_0005);
      chk("t1_pc", bus.pc, 32'd4);
      tick(1'b0, 1'b0, 2'd3);
      chk("t1_led", {24'b0, bus.led}, 32'h20);
      tick(1'b0, 1'b0, 2'd3);

      // Step, step during ISSUE, step during WAIT: two fetches.
      pc_before = bus.pc;
      tick(1'b1, 1'b0, 2'd1);
      tick(1'b1, 1'b0, 2'd1);
      tick(1'b1, 1'b0, 2'd1);
      tick(1'b0, 1'b0, 2'd1);
      chk("t2_second_issue", {31'b0, bus.rom_en}, 32'd1);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 2'd1);
      chk("t2_pc", bus.pc, pc_before + 32'd8);

      // Step coinciding with timer expiry merges into one fetch.
      tick(1'b0, 1'b0, 2'd0);
      pc_before = bus.pc;
      for (int i = 0; i < RUN_DIV - 1; i++) tick(1'b0, 1'b1, 2'd0);
      tick(1'b1, 1'b1, 2'd0);
      chk("t3_rom_en", {31'b0, bus.rom_en}, 32'd1);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 2'd0);
      chk("t3_pc", bus.pc, pc_before + 32'd4);

      // Free-run: four fetches at fixed spacing.
      got = 0;
      last = 0;
      for (int i = 0; i < 4 * 30 && got < 4; i++) begin
         tick(1'b0, 1'b1, 2'd2);
         if (bus.ir_valid) begin
            if (got > 0) chk("run_gap", n - last, RUN_DIV + ROM_LAT + 1);
            last = n;
            got++;
         end
      end
      chk("run_count", got, 32'd4);

      // Dropping Run mid-count restarts the full interval.
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 2'd2);
      tick(1'b0, 1'b0, 2'd2);
      k = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1'b0, 1'b1, 2'd2);
         if (k == 0 && bus.ir_valid) k = i + 1;
         if (k != 0) break;
      end
      chk("run_restart", k, RUN_DIV + ROM_LAT + 1);
      tick(1'b0, 1'b0, 2'd0);
      tick(1'b0, 1'b0, 2'd0);

      // 65 single steps from PC=0 wrap the word address.
      async_reset();
      for (int i = 0; i <= 64; i++) begin
         tick(1'b1, 1'b0, 2'(i));
         chk("wrap_addr", {26'b0, bus.rom_addr}, i % 64);
         if (i == 64) chk("wrap_pc", bus.pc, 32'h100);
         tick(1'b0, 1'b0, 2'(i));
         tick(1'b0, 1'b0, 2'(i));
      end

      // Random mix of steps, run toggles and byte selects.
      begin
         logic r;
         r = 1'b0;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(31) == 0) r = ~r;
            tick($urandom_range(3) == 0, r, 2'($urandom_range(3)));
         end
      end
      tick(1'b0, 1'b0, 2'd0);

      // Reset one cycle after ISSUE aborts the fetch.
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 2'd0);
      tick(1'b1, 1'b0, 2'd0);
      tick(1'b0, 1'b0, 2'd0);
      async_reset();
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_pc", bus.pc, 32'd0);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 2'd0);
      chk("rst_no_fetch", bus.pc, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
